// File: rtl/sega_pad_reader.sv
// Sega 3-button gamepad poller.
// Polls the pad once per POLL_DIV + 2*SETTLE + 1 clocks. Each poll reads the pins
// with select high, then with select low, and publishes the decoded buttons as
// active-high bits on SegaData together with a one-cycle sega_update pulse.
module sega_pad_reader #(
    parameter int unsigned POLL_DIV = 100000,
    parameter int unsigned SETTLE   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  pad_in,
    output logic        pad_sel,
    output logic [31:0] SegaData,
    output logic        sega_update,
    output logic        pad_present
);

    localparam int unsigned CW = 20;
    localparam logic [CW-1:0] IDLE_LOAD   = CW'(POLL_DIV - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        HI_SETTLE,
        LO_SETTLE,
        COMMIT
    } PollState;

    PollState      state;
    logic [CW-1:0] count;
    logic [5:0]    syncStage1;
    logic [5:0]    syncStage2;
    logic [5:0]    hiSmp;
    // With select low, pin1/pin2 only repeat Up/Down, so only {pin9, pin6, pin4, pin3} are kept.
    logic [3:0]    loSmp;
    logic          padDetected;
    logic [31:0]   commitData;

    // Two-flop synchronizer for the asynchronous pad pins; released (all ones) on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            syncStage1 <= 6'h3F;
            syncStage2 <= 6'h3F;
        end else begin
            syncStage1 <= pad_in;
            syncStage2 <= syncStage1;
        end
    end

    // Decode the two captured pin sets into the published button word.
    always_comb begin
        padDetected = 1'b0;
        commitData  = 32'd0;
        padDetected = ~loSmp[0] & ~loSmp[1];
        if (padDetected) begin
            commitData = {23'd0, 1'b1, ~loSmp[3], ~loSmp[2], ~hiSmp};
        end
    end

    // Poll sequencer: idle dwell, select-high sample, select-low sample, then commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= IDLE_LOAD;
            pad_sel     <= 1'b1;
            SegaData    <= 32'd0;
            sega_update <= 1'b0;
            pad_present <= 1'b0;
            hiSmp       <= 6'h3F;
            loSmp       <= 4'hF;
        end else begin
            sega_update <= 1'b0;
            case (state)
                IDLE: begin
                    if (count == '0) begin
                        state <= HI_SETTLE;
                        count <= SETTLE_LOAD;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                HI_SETTLE: begin
                    if (count == '0) begin
                        hiSmp   <= syncStage2;
                        state   <= LO_SETTLE;
                        count   <= SETTLE_LOAD;
                        pad_sel <= 1'b0;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                LO_SETTLE: begin
                    if (count == '0) begin
                        loSmp   <= syncStage2[5:2];
                        state   <= COMMIT;
                        pad_sel <= 1'b1;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                COMMIT: begin
                    SegaData    <= commitData;
                    pad_present <= padDetected;
                    sega_update <= 1'b1;
                    state       <= IDLE;
                    count       <= IDLE_LOAD;
                end
                default: begin
                    state   <= IDLE;
                    count   <= IDLE_LOAD;
                    pad_sel <= 1'b1;
                end
            endcase
        end
    end

endmodule
